// File: rtl/regfile_write_arbiter.sv
// Two-requester write-port arbiter for the 32x32 register file: one holding slot per
// requester, round-robin drain into registered write outputs, plus read-after-write flags.
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              regWrite,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic              hazard1,
  output logic              hazard2
);

  logic [1:0]        reqValid;
  logic [1:0]        reqReady;
  logic [1:0]        slotFull;
  logic [1:0]        grant;
  logic              grantIdx;
  logic              lastGrant;
  logic [1:0]        hazard;
  logic [ADDR_W-1:0] reqAddr  [2];
  logic [DATA_W-1:0] reqData  [2];
  logic [ADDR_W-1:0] slotAddr [2];
  logic [DATA_W-1:0] slotData [2];
  logic [ADDR_W-1:0] readAddr [2];

  assign reqValid    = {req1_valid, req0_valid};
  assign reqAddr[0]  = req0_addr;
  assign reqAddr[1]  = req1_addr;
  assign reqData[0]  = req0_data;
  assign reqData[1]  = req1_data;
  assign readAddr[0] = readReg1;
  assign readAddr[1] = readReg2;
  assign req0_ready  = reqReady[0];
  assign req1_ready  = reqReady[1];
  assign hazard1     = hazard[0];
  assign hazard2     = hazard[1];

  // On a tie the slot that did not win last time goes next; otherwise any full slot wins.
  always_comb begin
    grant = slotFull;
    if (slotFull == 2'b11) begin
      grant = lastGrant ? 2'b01 : 2'b10;
    end
  end

  assign grantIdx = grant[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gSlot
      logic              fullReg;
      logic [ADDR_W-1:0] addrReg;
      logic [DATA_W-1:0] dataReg;

      // Ready in the grant cycle lets a lone requester stream one write per cycle.
      assign reqReady[gi] = ~fullReg | grant[gi];
      assign slotFull[gi] = fullReg;
      assign slotAddr[gi] = addrReg;
      assign slotData[gi] = dataReg;

      always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
          fullReg <= 1'b0;
          addrReg <= '0;
          dataReg <= '0;
        end else if (reqValid[gi] && reqReady[gi]) begin
          fullReg <= 1'b1;
          addrReg <= reqAddr[gi];
          dataReg <= reqData[gi];
        end else if (grant[gi]) begin
          fullReg <= 1'b0;
        end
      end
    end

    for (gi = 0; gi < 2; gi++) begin : gHazard
      assign hazard[gi] = (readAddr[gi] != '0) &&
                          ((slotFull[0] && (slotAddr[0] == readAddr[gi])) ||
                           (slotFull[1] && (slotAddr[1] == readAddr[gi])) ||
                           (regWrite && (writeReg == readAddr[gi])));
    end
  endgenerate

  // Writes to $0 still consume the grant but never raise regWrite.
  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      regWrite  <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
      lastGrant <= 1'b1;
    end else if (|grant) begin
      regWrite  <= (slotAddr[grantIdx] != '0);
      writeReg  <= slotAddr[grantIdx];
      writeData <= slotData[grantIdx];
      lastGrant <= grantIdx;
    end else begin
      regWrite  <= 1'b0;
    end
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 32×32 `Register` file between two writeback requesters, for example the pipeline WB stage and a multicycle unit such as mult/div or a load return. Each requester hands off a (register, data) pair with a valid/ready handshake into a one-entry holding slot. A round-robin arbiter drains one slot per cycle into registered `regWrite`/`writeReg`/`writeData` outputs. The block also flags read-after-write hazards for the register file's two read addresses while a write is still in flight.

## Interface
- `DATA_W`, 32, width of write data
- `ADDR_W`, 5, width of register index

Ports:
- `clock_in`  in  1  sole clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low (0 = reset); release is synchronous to `clock_in`
- `req0_valid`  in  1  requester 0 offers a write
- `req0_ready`  out  1  slot 0 accepts this cycle
- `req0_addr`  in  ADDR_W  destination register
- `req0_data`  in  DATA_W  write value
- `req1_valid`, `req1_ready`, `req1_addr`, `req1_data`  same as requester 0, for requester 1
- `regWrite`  out  1  write enable to the register file (registered)
- `writeReg`  out  ADDR_W  write address (registered)
- `writeData`  out  DATA_W  write data (registered)
- `readReg1`  in  ADDR_W  register file read address 1 (observed only)
- `readReg2`  in  ADDR_W  register file read address 2 (observed only)
- `hazard1`  out  1  `readReg1` has a pending write (combinational)
- `hazard2`  out  1  `readReg2` has a pending write (combinational)

## Operation
- State:
  - slots 0/1: `full`, `addr`, `data`.
  - round-robin pointer `last`: 1 bit, the requester granted most recently.
  - output registers.
- Accept: `reqN_ready = !fullN | grantN`. On the edge where `reqN_valid & reqN_ready`, slot N loads addr/data and `fullN` = 1.
- Grant (combinational, each cycle):
  - Only one slot full: that slot is granted.
  - Both slots full: the slot ≠ `last` is granted.
  - No slot full: no grant.
- On the edge of a grant to slot N:
  - `writeReg`/`writeData` load slot N's contents.
  - `regWrite` = 1 if slot addr ≠ 0, otherwise 0. Writes to $0 are consumed and dropped.
  - `last` = N.
  - `fullN` = 0, unless a same-edge accept reloads it.
- Cycles with no grant: `regWrite` = 0; `writeReg`/`writeData` hold their values.
- Ordering:
  - Per requester: writes appear in issue order.
  - Between requesters: grant order only. Two pending writes to the same register resolve to whichever is granted last.
- `hazardK` = 1 when `readRegK` ≠ 0 and `readRegK` matches any of:
  - addr of a full slot;
  - `writeReg` while `regWrite` = 1.
- Reset (asynchronous, `reset` = 0):
  - `full0` = `full1` = 0; `last` = 1, so requester 0 wins the first tie.
  - `regWrite` = 0, `writeReg` = 0, `writeData` = 0.
  - Resulting combinational outputs: `req0_ready` = `req1_ready` = 1, `hazard1` = `hazard2` = 0.
  - Reset mid-operation discards all pending slot contents; no partial write is issued.

## Timing
- Latency:
  - Accept edge E: slot full after E.
  - Earliest grant on edge E+1: `regWrite`/`writeReg`/`writeData` valid after E+1.
  - Register file captures the write on edge E+2.
- Throughput:
  - One write per cycle in aggregate.
  - A single requester alone sustains one per cycle, because `ready` is asserted in its grant cycle.
  - Under contention, each requester gets one write per 2 cycles.
- `reqN_ready` depends on `valid` only through the grant, never on `reqN_valid` itself, so there is no combinational loop.
- Hazard timing: `hazardK` covers the interval from the accept edge through the cycle in which the register file is being written. It deasserts the cycle after `regWrite` drops for that address.

## Test plan
- **Reset.** Drive `reset`=0 mid-cycle with both slots full → immediately `regWrite`=0, `writeReg`=0, `writeData`=0, both `ready`=1. After release, no stale write appears.
- **Single requester.** req0 streams (1,255), (2,233), (3,7) back to back → `regWrite`=1 on 3 consecutive cycles with `writeReg` 1,2,3 and data 255,233,7; `req0_ready` stays 1.
- **Contention.**
  - Both requesters valid every cycle: req0 (4,10),(5,11); req1 (6,20),(7,21).
  - Required grant order: req0 first, then alternating, giving writes 4,6,5,7.
  - Each `ready` drops in alternate cycles.
- **$0 write.** req1 (0,99) → slot drains in 1 grant cycle, `regWrite` stays 0. With `readReg1`=0, `hazard1`=0 throughout.
- **Hazard.**
  - Sequence: `readReg1`=3, `readReg2`=9, req0 issues (3,233).
  - Required: `hazard1`=1 from the cycle after accept through the `regWrite` cycle, then 0; `hazard2`=0 throughout.
- **Same address, both requesters.**
  - Stimulus: both requesters offer a write to register 8 simultaneously, data 1 (req0) and 2 (req1), with `last`=1.
  - Required: 2 writes issued, req0's then req1's. Reading r8 from the register file afterwards returns 2.
